bram_serial_ctrl: RTL

- Serial command sequencer for one port (port A) of a RAMB18E1-class block RAM in the BRAM minitest flow.
- Commands shift in bit-serially on `di` and are latched by `stb`.
- An FSM drives the BRAM port for write, read and fill operations.
- Read data is loaded into an output shift register and streamed out on `do`. This lets a design exercise BRAM contents with only three top-level pins.

---
 rtl/bram_serial_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/bram_serial_ctrl.sv
// bram_serial_ctrl: serial command sequencer for port A of a RAMB18E1-class
// block RAM. Commands shift in MSB first on di_i and execute on stb_i. Read
// data streams back out MSB first on do_o, so three pins are enough to
// exercise the whole RAM.
//
// Command word, MSB first: {op[1:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}
//   op 00 NOP, 01 WRITE, 10 READ, 11 FILL (addr .. all-ones, no wrap)
//
// Optional build macro BRAM_SERIAL_CTRL_PARITY_EN appends one LSB even-parity
// bit covering the whole command. A strobed command with bad parity is
// dropped and raises err_o.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   di_i         serial command input
//   stb_i        latch/execute strobe (sampled in IDLE only)
//   do_o         serial read-data output
//   busy_o       high while a command executes
//   done_o       one-cycle completion pulse
//   err_o        sticky error (strobe while busy, or bad parity)
//   ram_en_o     BRAM enable       (combinational decode of state)
//   ram_we_o     BRAM write enable (combinational decode of state)
//   ram_addr_o   BRAM address
//   ram_din_o    BRAM write data
//   ram_dout_i   BRAM read data
module bram_serial_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              di_i,
  input  logic              stb_i,
  output logic              do_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

`ifdef BRAM_SERIAL_CTRL_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned CMD_W = 2 + ADDR_W + DATA_W + PAR_W;
  localparam int unsigned LAT_W = 2;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_FILL     = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4
  } state_e;

  state_e              state_q;
  logic [CMD_W-1:0]    cmd_shr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   dout_shr_q;
  logic [LAT_W-1:0]    lat_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [1:0]          cmd_op_c;
  logic [ADDR_W-1:0]   cmd_addr_c;
  logic [DATA_W-1:0]   cmd_data_c;
  logic                par_ok_c;
  logic                capture_c;

  // Command field decode straight off the shift register
  assign cmd_op_c   = cmd_shr_q[CMD_W-1 -: 2];
  assign cmd_addr_c = cmd_shr_q[CMD_W-3 -: ADDR_W];
  assign cmd_data_c = cmd_shr_q[PAR_W +: DATA_W];

`ifdef BRAM_SERIAL_CTRL_PARITY_EN
  assign par_ok_c = ~(^cmd_shr_q);
`else
  assign par_ok_c = 1'b1;
`endif

  // Last RD_WAIT cycle: BRAM output is valid on this edge
  assign capture_c = (state_q == S_RD_WAIT) && (lat_q == '0);

  // RAM port is a pure decode of state so reset drops ram_en_o at once
  assign ram_en_o   = (state_q == S_WRITE) || (state_q == S_FILL) ||
                      (state_q == S_RD_ISSUE);
  assign ram_we_o   = (state_q == S_WRITE) || (state_q == S_FILL);
  assign ram_addr_o = addr_q;
  assign ram_din_o  = data_q;

  assign do_o   = dout_shr_q[DATA_W-1];
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  // Command shift register, free running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_shr_q <= '0;
    end else begin
      cmd_shr_q <= {cmd_shr_q[CMD_W-2:0], di_i};
    end
  end

  // Output shift register; a read capture wins over the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_shr_q <= '0;
    end else if (capture_c) begin
      dout_shr_q <= ram_dout_i;
    end else begin
      dout_shr_q <= {dout_shr_q[DATA_W-2:0], 1'b0};
    end
  end

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (stb_i) begin
            if (!par_ok_c) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              addr_q <= cmd_addr_c;
              data_q <= cmd_data_c;
              case (cmd_op_c)
                OP_NOP: begin
                  err_q  <= 1'b0;
                  done_q <= 1'b1;
                end
                OP_WRITE: begin
                  state_q <= S_WRITE;
                  busy_q  <= 1'b1;
                end
                OP_READ: begin
                  state_q <= S_RD_ISSUE;
                  busy_q  <= 1'b1;
                end
                default: begin
                  state_q <= S_FILL;
                  busy_q  <= 1'b1;
                end
              endcase
            end
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        S_FILL: begin
          // Stop after the all-ones address instead of wrapping to zero
          if (addr_q == '1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_RD_ISSUE: begin
          state_q <= S_RD_WAIT;
          lat_q   <= LAT_W'(READ_LAT - 1);
        end
        S_RD_WAIT: begin
          if (lat_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Strobe while busy is dropped but flagged
      if (stb_i && (state_q != S_IDLE)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
